// File: rtl/dram_block_server.sv
`timescale 1ns/1ps
// Memory-side responder for the per-queue block DRAM protocol: one block write and
// one block read stream share a single-port fixed-latency memory by alternating priority.
module dram_block_server #(
  parameter int DRAM_ADDR_WIDTH = 22,
  parameter int DRAM_DATA_WIDTH = 144,
  parameter int BLOCK_WORDS     = 8,
  parameter int MEM_RD_LATENCY  = 2,
  parameter int WR_FIFO_DEPTH   = 4,
  parameter int RD_FIFO_DEPTH   = 4,
  localparam int WIDX_W         = $clog2(BLOCK_WORDS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              dram_wr_req,
  input  logic [DRAM_ADDR_WIDTH-1:0]        dram_wr_ptr,
  input  logic                              dram_wr_data_vld,
  input  logic [DRAM_DATA_WIDTH-1:0]        dram_wr_data,
  output logic                              dram_wr_ack,
  output logic                              dram_wr_full,
  output logic                              dram_wr_done,
  input  logic                              dram_rd_req,
  input  logic [DRAM_ADDR_WIDTH-1:0]        dram_rd_ptr,
  input  logic                              dram_rd_en,
  output logic [DRAM_DATA_WIDTH-1:0]        dram_rd_data,
  output logic                              dram_rd_ack,
  output logic                              dram_rd_rdy,
  output logic                              dram_rd_done,
  output logic [DRAM_ADDR_WIDTH+WIDX_W-1:0] mem_addr,
  output logic                              mem_wr_en,
  output logic [DRAM_DATA_WIDTH-1:0]        mem_wr_data,
  output logic                              mem_rd_en,
  input  logic [DRAM_DATA_WIDTH-1:0]        mem_rd_data
);

  localparam int WP_W = (WR_FIFO_DEPTH > 1) ? $clog2(WR_FIFO_DEPTH) : 1;
  localparam int RP_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam int WC_W = $clog2(WR_FIFO_DEPTH + 1);
  localparam int RC_W = $clog2(RD_FIFO_DEPTH + 1);
  localparam int FL_W = $clog2(RD_FIFO_DEPTH + MEM_RD_LATENCY + 2);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    WR_IDLE = 3'd0, WR_ACK = 3'd1, WR_DATA = 3'd2, WR_DRAIN = 3'd3, WR_DONE = 3'd4
  } wr_state_t;
  typedef enum logic [2:0] {
    RD_IDLE = 3'd0, RD_ACK = 3'd1, RD_FETCH = 3'd2, RD_DRAIN = 3'd3, RD_DONE = 3'd4
  } rd_state_t;

  wr_state_t wr_state_r, wr_state_s;
  rd_state_t rd_state_r, rd_state_s;

  logic [DRAM_ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
  logic [DRAM_DATA_WIDTH-1:0] wr_fifo_r [WR_FIFO_DEPTH];
  logic [DRAM_DATA_WIDTH-1:0] rd_fifo_r [RD_FIFO_DEPTH];
  logic [WP_W-1:0]            wr_head_r, wr_tail_r;
  logic [RP_W-1:0]            rd_head_r, rd_tail_r;
  logic [WC_W-1:0]            wr_count_r;
  logic [RC_W-1:0]            rd_count_r;
  logic [WIDX_W-1:0]          wr_words_r, wr_idx_r, rd_idx_r, rd_pop_idx_r;
  logic [MEM_RD_LATENCY:0]    rd_pipe_r;
  logic                       last_rd_r;

  logic            wr_push_s, wr_cand_s, rd_cand_s, rd_credit_s;
  logic            gnt_wr_s, gnt_rd_s, rd_pop_s, rd_fill_s;
  logic [FL_W-1:0] rd_inflight_s;

  function automatic logic [WP_W-1:0] wr_ptr_inc(input logic [WP_W-1:0] p);
    if (p == WP_W'(WR_FIFO_DEPTH - 1)) return '0;
    else return p + WP_W'(1);
  endfunction

  function automatic logic [RP_W-1:0] rd_ptr_inc(input logic [RP_W-1:0] p);
    if (p == RP_W'(RD_FIFO_DEPTH - 1)) return '0;
    else return p + RP_W'(1);
  endfunction

  // Handshake decode, credit and port arbitration
  always_comb begin
    wr_push_s     = (wr_state_r == WR_DATA) && dram_wr_data_vld && !dram_wr_full;
    rd_pop_s      = dram_rd_en && dram_rd_rdy;
    rd_fill_s     = rd_pipe_r[MEM_RD_LATENCY];
    rd_inflight_s = '0;
    for (int i = 0; i <= MEM_RD_LATENCY; i++) begin
      rd_inflight_s = rd_inflight_s + FL_W'(rd_pipe_r[i]);
    end
    // Issued-but-unreturned reads reserve FIFO space so returns can never overflow
    rd_credit_s = (FL_W'(rd_count_r) + rd_inflight_s) < FL_W'(RD_FIFO_DEPTH);
    wr_cand_s   = (wr_count_r != '0);
    rd_cand_s   = (rd_state_r == RD_FETCH) && rd_credit_s;
    gnt_wr_s    = wr_cand_s && (!rd_cand_s || last_rd_r);
    gnt_rd_s    = rd_cand_s && (!wr_cand_s || !last_rd_r);
  end

  // FSM state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_r <= WR_IDLE;
      rd_state_r <= RD_IDLE;
    end else begin
      wr_state_r <= wr_state_s;
      rd_state_r <= rd_state_s;
    end
  end

  // Write FSM next state
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      WR_IDLE:  if (dram_wr_req) wr_state_s = WR_ACK; else wr_state_s = WR_IDLE;
      WR_ACK:   wr_state_s = WR_DATA;
      WR_DATA:  if (wr_push_s && (wr_words_r == LAST_IDX)) wr_state_s = WR_DRAIN;
                else wr_state_s = WR_DATA;
      WR_DRAIN: if (wr_count_r == '0) wr_state_s = WR_DONE; else wr_state_s = WR_DRAIN;
      WR_DONE:  wr_state_s = WR_IDLE;
      default:  wr_state_s = WR_IDLE;
    endcase
  end

  // Read FSM next state
  always_comb begin
    rd_state_s = rd_state_r;
    case (rd_state_r)
      RD_IDLE:  if (dram_rd_req) rd_state_s = RD_ACK; else rd_state_s = RD_IDLE;
      RD_ACK:   rd_state_s = RD_FETCH;
      RD_FETCH: if (gnt_rd_s && (rd_idx_r == LAST_IDX)) rd_state_s = RD_DRAIN;
                else rd_state_s = RD_FETCH;
      RD_DRAIN: if (rd_pop_s && (rd_pop_idx_r == LAST_IDX)) rd_state_s = RD_DONE;
                else rd_state_s = RD_DRAIN;
      RD_DONE:  rd_state_s = RD_IDLE;
      default:  rd_state_s = RD_IDLE;
    endcase
  end

  // Client-facing outputs, decoded from registers only
  always_comb begin
    dram_wr_ack  = 1'b0;
    dram_wr_done = 1'b0;
    dram_rd_ack  = 1'b0;
    dram_rd_done = 1'b0;
    case (wr_state_r)
      WR_ACK:  dram_wr_ack  = 1'b1;
      WR_DONE: dram_wr_done = 1'b1;
      default: dram_wr_ack  = 1'b0;
    endcase
    case (rd_state_r)
      RD_ACK:  dram_rd_ack  = 1'b1;
      RD_DONE: dram_rd_done = 1'b1;
      default: dram_rd_ack  = 1'b0;
    endcase
    dram_wr_full = (wr_count_r == WC_W'(WR_FIFO_DEPTH));
    dram_rd_rdy  = (rd_count_r != '0);
    if (dram_rd_rdy) dram_rd_data = rd_fifo_r[rd_head_r];
    else dram_rd_data = '0;
  end

  // Write staging FIFO, pointer latch and word counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      wr_head_r  <= '0;
      wr_tail_r  <= '0;
      wr_count_r <= '0;
      wr_words_r <= '0;
      wr_idx_r   <= '0;
      for (int i = 0; i < WR_FIFO_DEPTH; i++) wr_fifo_r[i] <= '0;
    end else begin
      if ((wr_state_r == WR_IDLE) && dram_wr_req) wr_ptr_r <= dram_wr_ptr;
      if (wr_state_r == WR_ACK) wr_words_r <= '0;
      else if (wr_push_s) wr_words_r <= wr_words_r + WIDX_W'(1);
      if (wr_push_s) begin
        wr_fifo_r[wr_tail_r] <= dram_wr_data;
        wr_tail_r            <= wr_ptr_inc(wr_tail_r);
      end
      if (gnt_wr_s) begin
        wr_head_r <= wr_ptr_inc(wr_head_r);
        wr_idx_r  <= wr_idx_r + WIDX_W'(1);
      end
      case ({wr_push_s, gnt_wr_s})
        2'b10:   wr_count_r <= wr_count_r + WC_W'(1);
        2'b01:   wr_count_r <= wr_count_r - WC_W'(1);
        default: wr_count_r <= wr_count_r;
      endcase
    end
  end

  // Read return FIFO, latency pipe and issue/pop counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r     <= '0;
      rd_head_r    <= '0;
      rd_tail_r    <= '0;
      rd_count_r   <= '0;
      rd_idx_r     <= '0;
      rd_pop_idx_r <= '0;
      rd_pipe_r    <= '0;
      for (int i = 0; i < RD_FIFO_DEPTH; i++) rd_fifo_r[i] <= '0;
    end else begin
      if ((rd_state_r == RD_IDLE) && dram_rd_req) rd_ptr_r <= dram_rd_ptr;
      rd_pipe_r <= {rd_pipe_r[MEM_RD_LATENCY-1:0], gnt_rd_s};
      if (rd_state_r == RD_ACK) begin
        rd_idx_r     <= '0;
        rd_pop_idx_r <= '0;
      end else begin
        if (gnt_rd_s) rd_idx_r <= rd_idx_r + WIDX_W'(1);
        if (rd_pop_s) rd_pop_idx_r <= rd_pop_idx_r + WIDX_W'(1);
      end
      if (rd_fill_s) begin
        rd_fifo_r[rd_tail_r] <= mem_rd_data;
        rd_tail_r            <= rd_ptr_inc(rd_tail_r);
      end
      if (rd_pop_s) rd_head_r <= rd_ptr_inc(rd_head_r);
      case ({rd_fill_s, rd_pop_s})
        2'b10:   rd_count_r <= rd_count_r + RC_W'(1);
        2'b01:   rd_count_r <= rd_count_r - RC_W'(1);
        default: rd_count_r <= rd_count_r;
      endcase
    end
  end

  // Registered memory port and alternating-priority history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      mem_rd_en   <= 1'b0;
      last_rd_r   <= 1'b1;
    end else begin
      mem_wr_en <= gnt_wr_s;
      mem_rd_en <= gnt_rd_s;
      if (gnt_wr_s) begin
        mem_addr    <= {wr_ptr_r, wr_idx_r};
        mem_wr_data <= wr_fifo_r[wr_head_r];
        last_rd_r   <= 1'b0;
      end else if (gnt_rd_s) begin
        mem_addr  <= {rd_ptr_r, rd_idx_r};
        last_rd_r <= 1'b1;
      end else begin
        mem_addr  <= mem_addr;
        last_rd_r <= last_rd_r;
      end
    end
  end

endmodule
